// File: rtl/erasure_position_gen.sv
// Erasure position generator for a RS(255,k) decoder over GF(256), poly 0x11D.
// Collects the locator value alpha^(254-i) of every erased symbol in a frame,
// then streams the stored locators to the error locator on request.
//
// Handshake: erasure_ready is a one-cycle qualifier for erase_position; the
// locator keeps send_erasure_positions_for_loc high to pull one entry per
// cycle and may drop it at any time to pause. There is no backpressure on the
// symbol input side: every symbol_valid cycle in IDLE/COLLECT is consumed.
module erasure_position_gen #(
    parameter int width        = 5,
    parameter int max_erasures = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             symbol_valid,
    input  logic             erasure_flag,
    input  logic             last_symbol,
    input  logic             send_erasure_positions_for_loc,
    output logic [7:0]       erase_position,
    output logic             erasure_ready,
    output logic             erase_pos_done,
    output logic [width-1:0] number_of_erasures,
    output logic             positions_valid,
    output logic             erasure_overflow,
    output logic [2:0]       state_dbg_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        HOLD    = 3'd2,
        SEND    = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int               IDX_W    = (max_erasures > 1) ? $clog2(max_erasures) : 1;
    localparam logic [width-1:0] MAX_CNT  = width'(max_erasures);
    localparam logic [width-1:0] ONE_CNT  = width'(1);
    localparam logic [7:0]       LOC_INIT = 8'h8E;  // alpha^254, locator of index 0

    // Multiply by alpha^-1: reduce by the primitive polynomial when odd, then halve.
    function automatic logic [7:0] mul_alpha_inv(input logic [7:0] v);
        logic [8:0] t;
        t = v[0] ? ({1'b0, v} ^ 9'h11D) : {1'b0, v};
        return t[8:1];
    endfunction

    state_t           state_q, state_d;
    logic [width-1:0] count_q, count_d;
    logic [width-1:0] rd_ptr_q, rd_ptr_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       loc_q, loc_d;
    logic [7:0]       pos_q, pos_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             pv_q, pv_d;

    logic [7:0]       buf_q [max_erasures];
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [7:0]       wr_data;
    logic [IDX_W-1:0] rd_idx;
    logic [7:0]       rd_data;

    // Frame-start view: in IDLE the incoming symbol is index 0 of a fresh frame.
    logic             in_idle;
    logic [width-1:0] cnt_base;
    logic             ovf_base;
    logic [7:0]       loc_cur;

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            loc_q    <= LOC_INIT;
            pos_q    <= 8'h00;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            pv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            loc_q    <= loc_d;
            pos_q    <= pos_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            pv_q     <= pv_d;
        end
    end

    // Position buffer; contents are only ever read below the stored count.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            buf_q[wr_idx] <= wr_data;
        end
    end

    // Next-state, buffer write and output generation.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        loc_d    = loc_q;
        pos_d    = pos_q;
        ready_d  = 1'b0;
        done_d   = done_q;
        pv_d     = pv_q;

        in_idle  = (state_q == IDLE);
        cnt_base = in_idle ? '0 : count_q;
        ovf_base = in_idle ? 1'b0 : ovf_q;
        loc_cur  = in_idle ? LOC_INIT : loc_q;

        wr_en    = 1'b0;
        wr_idx   = cnt_base[IDX_W-1:0];
        wr_data  = loc_cur;

        rd_idx   = (state_q == HOLD) ? '0 : rd_ptr_q[IDX_W-1:0];
        rd_data  = buf_q[rd_idx];

        unique case (state_q)
            IDLE, COLLECT: begin
                if (symbol_valid) begin
                    count_d = cnt_base;
                    ovf_d   = ovf_base;
                    if (in_idle) begin
                        rd_ptr_d = '0;
                    end
                    if (erasure_flag) begin
                        if (cnt_base == MAX_CNT) begin
                            ovf_d = 1'b1;
                        end else begin
                            wr_en   = 1'b1;
                            count_d = cnt_base + ONE_CNT;
                        end
                    end
                    if (last_symbol) begin
                        state_d = HOLD;
                        pv_d    = 1'b1;
                        loc_d   = LOC_INIT;
                    end else begin
                        state_d = COLLECT;
                        loc_d   = mul_alpha_inv(loc_cur);
                    end
                end
            end
            HOLD: begin
                if (send_erasure_positions_for_loc) begin
                    if (count_q == '0) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        rd_ptr_d = '0;
                    end else begin
                        state_d  = SEND;
                        ready_d  = 1'b1;
                        pos_d    = rd_data;
                        rd_ptr_d = ONE_CNT;
                    end
                end
            end
            SEND: begin
                if (send_erasure_positions_for_loc) begin
                    if (rd_ptr_q == count_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        ready_d  = 1'b1;
                        pos_d    = rd_data;
                        rd_ptr_d = rd_ptr_q + ONE_CNT;
                    end
                end
            end
            DONE: begin
                if (!send_erasure_positions_for_loc) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                    pv_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign erase_position     = pos_q;
    assign erasure_ready      = ready_q;
    assign erase_pos_done     = done_q;
    assign number_of_erasures = count_q;
    assign positions_valid    = pv_q;
    assign erasure_overflow   = ovf_q;
    assign state_dbg_o        = state_q;

endmodule

// File: tb/tb_erasure_position_gen.sv
// Self-checking bench for erasure_position_gen: table of whole frames plus
// hand-written sequences for pause/resume, reset during SEND and ignored
// symbols outside collection.
module tb_erasure_position_gen;

    logic       clock = 1'b0;
    logic       reset;
    logic       symbol_valid;
    logic       erasure_flag;
    logic       last_symbol;
    logic       send_req;
    logic [7:0] erase_position;
    logic       erasure_ready;
    logic       erase_pos_done;
    logic [4:0] number_of_erasures;
    logic       positions_valid;
    logic       erasure_overflow;
    logic [2:0] state_dbg;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        logic [254:0] mask;
        bit           gaps;
        int           exp_cnt;
        bit           exp_ovf;
        logic [7:0]   exp_last;
    } vec_t;

    vec_t vecs[6];

    erasure_position_gen #(.width(5), .max_erasures(16)) dut (
        .clock                          (clock),
        .reset                          (reset),
        .symbol_valid                   (symbol_valid),
        .erasure_flag                   (erasure_flag),
        .last_symbol                    (last_symbol),
        .send_erasure_positions_for_loc (send_req),
        .erase_position                 (erase_position),
        .erasure_ready                  (erasure_ready),
        .erase_pos_done                 (erase_pos_done),
        .number_of_erasures             (number_of_erasures),
        .positions_valid                (positions_valid),
        .erasure_overflow               (erasure_overflow),
        .state_dbg_o                    (state_dbg)
    );

    // clock / reset block
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Forward model: alpha^k by repeated multiply-by-alpha.
    function automatic logic [7:0] alpha_pow(input int k);
        logic [8:0] v;
        v = 9'h001;
        for (int j = 0; j < k; j++) begin
            v = v << 1;
            if (v[8]) v = v ^ 9'h11D;
        end
        return v[7:0];
    endfunction

    task automatic build_exp(input logic [254:0] mask);
        int n;
        n = 0;
        exp_q.delete();
        for (int i = 0; i < 255; i++) begin
            if (mask[i] && n < 16) begin
                exp_q.push_back(alpha_pow(254 - i));
                n++;
            end
        end
    endtask

    task automatic send_frame(input logic [254:0] mask, input bit gaps);
        for (int i = 0; i < 255; i++) begin
            if (gaps && (i % 7 == 3)) begin
                symbol_valid = 1'b0;
                erasure_flag = 1'b1;
                last_symbol  = 1'b0;
                tick();
            end
            symbol_valid = 1'b1;
            erasure_flag = mask[i];
            last_symbol  = (i == 254);
            tick();
        end
        symbol_valid = 1'b0;
        erasure_flag = 1'b0;
        last_symbol  = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pos"},   32'(erase_position), 32'h0);
        check({tag, "_rdy"},   32'(erasure_ready), 32'h0);
        check({tag, "_done"},  32'(erase_pos_done), 32'h0);
        check({tag, "_cnt"},   32'(number_of_erasures), 32'h0);
        check({tag, "_pv"},    32'(positions_valid), 32'h0);
        check({tag, "_ovf"},   32'(erasure_overflow), 32'h0);
        check({tag, "_state"}, 32'(state_dbg), 32'h0);
    endtask

    // Hold request from HOLD until done; check values, pulse count and timing.
    task automatic drain(input string tag, input int exp_cnt, input logic [7:0] exp_last);
        int         cyc;
        int         npulse;
        bit         done_seen;
        logic [7:0] last_pos;
        cyc = 0;
        npulse = 0;
        done_seen = 1'b0;
        last_pos = 8'h00;
        send_req = 1'b1;
        while (!done_seen && cyc < 64) begin
            tick();
            cyc++;
            if (erasure_ready) begin
                npulse++;
                last_pos = erase_position;
                if (exp_q.size() == 0) check({tag, "_extra_pulse"}, 32'(erase_position), 32'hFFFF);
                else check({tag, "_pulse"}, 32'(erase_position), 32'(exp_q.pop_front()));
            end
            if (erase_pos_done) done_seen = 1'b1;
        end
        check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cnt + 1));
        check({tag, "_npulse"}, 32'(npulse), 32'(exp_cnt));
        check({tag, "_unsent"}, 32'(exp_q.size()), 32'h0);
        if (exp_cnt > 0) check({tag, "_last"}, 32'(last_pos), 32'(exp_last));
        tick();
        check({tag, "_done_hold"}, 32'(erase_pos_done), 32'h1);
        check({tag, "_pv_hold"}, 32'(positions_valid), 32'h1);
        check({tag, "_rdy_low"}, 32'(erasure_ready), 32'h0);
        if (exp_cnt > 0) check({tag, "_pos_held"}, 32'(erase_position), 32'(exp_last));
        send_req = 1'b0;
        tick();
        check({tag, "_done_clr"}, 32'(erase_pos_done), 32'h0);
        check({tag, "_pv_clr"}, 32'(positions_valid), 32'h0);
        check({tag, "_idle"}, 32'(state_dbg), 32'h0);
    endtask

    initial begin
        logic [254:0] m;

        reset        = 1'b1;
        symbol_valid = 1'b0;
        erasure_flag = 1'b0;
        last_symbol  = 1'b0;
        send_req     = 1'b0;
        tick();
        tick();
        check_reset_state("rst");
        reset = 1'b0;
        tick();

        // frame table
        vecs[0].mask = '0;
        vecs[0].mask[0] = 1'b1; vecs[0].mask[1] = 1'b1; vecs[0].mask[2] = 1'b1; vecs[0].mask[254] = 1'b1;
        vecs[0].gaps = 1'b0; vecs[0].exp_cnt = 4;  vecs[0].exp_ovf = 1'b0; vecs[0].exp_last = 8'h01;
        vecs[1].mask = '0;
        vecs[1].gaps = 1'b0; vecs[1].exp_cnt = 0;  vecs[1].exp_ovf = 1'b0; vecs[1].exp_last = 8'h00;
        vecs[2].mask = '0;
        for (int i = 0; i < 20; i++) vecs[2].mask[i] = 1'b1;
        vecs[2].gaps = 1'b0; vecs[2].exp_cnt = 16; vecs[2].exp_ovf = 1'b1; vecs[2].exp_last = 8'h16;
        vecs[3].mask = '0;
        vecs[3].mask[5] = 1'b1; vecs[3].mask[100] = 1'b1; vecs[3].mask[254] = 1'b1;
        vecs[3].gaps = 1'b1; vecs[3].exp_cnt = 3;  vecs[3].exp_ovf = 1'b0; vecs[3].exp_last = 8'h01;
        vecs[4].mask = '0;
        for (int i = 239; i < 255; i++) vecs[4].mask[i] = 1'b1;
        vecs[4].gaps = 1'b0; vecs[4].exp_cnt = 16; vecs[4].exp_ovf = 1'b0; vecs[4].exp_last = 8'h01;
        vecs[5].mask = '0;
        for (int i = 0; i < 17; i++) vecs[5].mask[i] = 1'b1;
        vecs[5].gaps = 1'b0; vecs[5].exp_cnt = 16; vecs[5].exp_ovf = 1'b1; vecs[5].exp_last = 8'h16;

        for (int v = 0; v < 6; v++) begin
            string tag;
            tag = $sformatf("v%0d", v);
            build_exp(vecs[v].mask);
            send_frame(vecs[v].mask, vecs[v].gaps);
            check({tag, "_pv"}, 32'(positions_valid), 32'h1);
            check({tag, "_cnt"}, 32'(number_of_erasures), 32'(vecs[v].exp_cnt));
            check({tag, "_ovf"}, 32'(erasure_overflow), 32'(vecs[v].exp_ovf));
            tick();
            check({tag, "_hold"}, 32'(state_dbg), 32'h2);
            drain(tag, vecs[v].exp_cnt, vecs[v].exp_last);
        end

        // pause after 2 of 4 pulses, resume
        m = '0;
        m[0] = 1'b1; m[1] = 1'b1; m[2] = 1'b1; m[254] = 1'b1;
        send_frame(m, 1'b0);
        send_req = 1'b1;
        tick();
        check("pz_p0", 32'({erasure_ready, erase_position}), 32'h18E);
        tick();
        check("pz_p1", 32'({erasure_ready, erase_position}), 32'h147);
        send_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("pz_paused", 32'({erasure_ready, erase_position}), 32'h047);
        end
        send_req = 1'b1;
        tick();
        check("pz_p2", 32'({erasure_ready, erase_position}), 32'h1AD);
        tick();
        check("pz_p3", 32'({erasure_ready, erase_position}), 32'h101);
        tick();
        check("pz_done", 32'({erasure_ready, erase_pos_done}), 32'h1);
        send_req = 1'b0;
        tick();

        // reset during SEND after one pulse
        m = '0;
        m[0] = 1'b1; m[1] = 1'b1;
        send_frame(m, 1'b0);
        send_req = 1'b1;
        tick();
        check("rs_p0", 32'({erasure_ready, erase_position}), 32'h18E);
        reset = 1'b1;
        tick();
        check_reset_state("rs");
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rs_no_pulse", 32'({erasure_ready, erase_pos_done}), 32'h0);
        end
        send_req = 1'b0;
        tick();
        m = '0;
        m[254] = 1'b1;
        build_exp(m);
        send_frame(m, 1'b0);
        check("rs_cnt", 32'(number_of_erasures), 32'h1);
        drain("rs_after", 1, 8'h01);

        // symbols ignored in HOLD/SEND/DONE
        m = '0;
        m[3] = 1'b1; m[7] = 1'b1;
        send_frame(m, 1'b0);
        symbol_valid = 1'b1;
        erasure_flag = 1'b1;
        last_symbol  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("ig_hold_cnt", 32'(number_of_erasures), 32'h2);
            check("ig_hold_state", 32'(state_dbg), 32'h2);
        end
        last_symbol = 1'b0;
        send_req = 1'b1;
        tick();
        check("ig_p0", 32'({erasure_ready, erase_position}), 32'h1D8);
        tick();
        check("ig_p1", 32'({erasure_ready, erase_position}), 32'h183);
        tick();
        check("ig_done", 32'({erase_pos_done, number_of_erasures}), 32'h22);
        send_req = 1'b0;
        tick();
        check("ig_idle", 32'({state_dbg, number_of_erasures}), 32'h02);
        tick();
        check("ig_restart", 32'({state_dbg, number_of_erasures}), 32'h21);
        symbol_valid = 1'b0;
        erasure_flag = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/erasure_position_gen.md
ERASURE_POSITION_GEN -- requirements
Module: erasure_position_gen

Interface
REQ-001 SHALL have parameter width, default 5, bit width of erasure count ports.
REQ-002 SHALL have parameter max_erasures, default 16, capacity of the position buffer.
REQ-003 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port symbol_valid  input  1  one received codeword symbol presented this cycle.
REQ-006 SHALL have port erasure_flag  input  1  current symbol is erased; qualified by symbol_valid.
REQ-007 SHALL have port last_symbol  input  1  current symbol is the 255th (final) symbol of the codeword; qualified by symbol_valid.
REQ-008 SHALL have port send_erasure_positions_for_loc  input  1  downstream locator requests positions; level-sensitive.
REQ-009 SHALL have port erase_position  output  8  GF(256) locator alpha^(254-i) of an erased symbol at index i.
REQ-010 SHALL have port erasure_ready  output  1  erase_position valid this cycle; one-cycle pulse per position.
REQ-011 SHALL have port erase_pos_done  output  1  all stored positions have been sent.
REQ-012 SHALL have port number_of_erasures  output  width  count of stored erasures for the frame.
REQ-013 SHALL have port positions_valid  output  1  frame collected; number_of_erasures stable.
REQ-014 SHALL have port erasure_overflow  output  1  frame had more than max_erasures erasures.

Function
REQ-015 SHALL use GF(256) with primitive polynomial 0x11D, codeword length n=255, first received symbol index i=0 (degree 254).
REQ-016 SHALL keep a running locator register, 0x8E (alpha^254) at frame start, updated per accepted symbol by multiply with alpha^-1: lsb 0 -> value>>1; lsb 1 -> (value^0x11D)>>1.
REQ-017 SHALL implement states IDLE, COLLECT, HOLD, SEND, DONE.
REQ-018 IDLE: first symbol_valid starts frame (index 0), enters COLLECT, clears count, overflow, buffer pointers.
REQ-019 COLLECT: each symbol_valid with erasure_flag=1 SHALL write current locator value to buffer[count] and increment count.
REQ-020 An erased symbol beyond max_erasures SHALL not be stored; count SHALL saturate at max_erasures; erasure_overflow SHALL set and hold until next frame start.
REQ-021 symbol_valid with last_symbol=1 (including the frame-starting symbol) SHALL be processed as in REQ-019, then enter HOLD next cycle with positions_valid=1 and number_of_erasures final.
REQ-022 symbol_valid SHALL be ignored in HOLD, SEND and DONE.
REQ-023 HOLD: send_erasure_positions_for_loc=1 SHALL enter SEND, or DONE directly if count is 0.
REQ-024 SEND: one buffered position per cycle in ascending index order, erasure_ready=1 with erase_position, first pulse the cycle after request seen in HOLD; no gaps while request held.
REQ-025 SEND: request dropping SHALL pause output (erasure_ready=0, read pointer held); reassertion resumes from the next unsent entry.
REQ-026 After the last position is sent, SHALL enter DONE and assert erase_pos_done the following cycle.
REQ-027 DONE: erase_pos_done and positions_valid SHALL stay 1 while request high; request low SHALL return to IDLE, clearing both next cycle.
REQ-028 erase_position SHALL hold its last value when erasure_ready=0.

Reset
REQ-029 reset SHALL force IDLE and clear erase_position=0x00, erasure_ready=0, erase_pos_done=0, number_of_erasures=0, positions_valid=0, erasure_overflow=0, locator=0x8E.
REQ-030 reset asserted mid-frame or mid-SEND SHALL abandon the frame; no further erasure_ready pulses until a new frame completes.
REQ-031 Buffer contents need no reset; unread entries SHALL never be output.

Verification
REQ-032 Frame with erasures at i=0,1,2,254, request held -> positions_valid, count 4; pulses 0x8E, 0x47, 0xAD, 0x01 on consecutive cycles; erase_pos_done next cycle.
REQ-033 Frame with no erasures, request asserted -> no erasure_ready; erase_pos_done=1 one cycle after request seen; count 0.
REQ-034 Frame with 20 erasures at i=0..19 -> count 16, erasure_overflow=1, exactly 16 pulses, last being alpha^239.
REQ-035 Request dropped after 2 of 4 pulses for 3 cycles, then reasserted -> remaining 2 positions in order, none repeated or lost.
REQ-036 reset during SEND after 1 pulse -> all outputs at reset values next cycle; following frame with erasure at i=254 yields single pulse 0x01.
REQ-037 symbol_valid pulses during HOLD/SEND -> count and buffer unchanged; next frame starts only after DONE->IDLE.
